seq_player_ctrl: RTL
====================

SEQ_PLAYER_CTRL -- requirements
Module: seq_player_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4, the width of each pattern entry and of result.
REQ-002 SHALL have parameter DIV_W, default 8, the width of the step-rate divider.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port cfg_we, input, 1 bit: pattern write strobe.
REQ-006 SHALL have port cfg_addr, input, 3 bits: pattern entry index, 0..7.
REQ-007 SHALL have port cfg_data, input, DATA_W bits: pattern write data.
REQ-008 SHALL have port cfg_div, input, DIV_W bits: step divisor, latched on start.
REQ-009 SHALL have port cfg_len, input, 4 bits: sequence length, latched on start.
REQ-010 SHALL have port loop_en, input, 1 bit: repeat the sequence, latched on start.
REQ-011 SHALL have port start, input, 1 bit: begin playback.
REQ-012 SHALL have port stop, input, 1 bit: abort playback.
REQ-013 SHALL have port pause, input, 1 bit: freeze the step timer while high.
REQ-014 SHALL have port result, output, DATA_W bits: current pattern value.
REQ-015 SHALL have port result_valid, output, 1 bit: result is offered downstream.
REQ-016 SHALL have port result_ready, input, 1 bit: downstream accepts result.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a non-looping sequence.

Function
REQ-019 SHALL hold an 8-entry x DATA_W pattern memory; cfg_we writes cfg_data to entry cfg_addr in IDLE only, and writes in any other state SHALL be ignored.
REQ-020 SHALL implement the states IDLE, RUN and WAIT.
REQ-021 IDLE: when start=1 and cfg_len!=0, the block SHALL latch div_q=cfg_div, len_q=min(cfg_len,8) and loop_q=loop_en, set idx=0 and cnt=0, and enter RUN; start with cfg_len=0 SHALL be ignored.
REQ-022 RUN: cnt SHALL increment each cycle pause=0 and hold while pause=1.
REQ-023 RUN: when cnt==div_q and pause=0, the block SHALL set cnt=0, result=mem[idx] and result_valid=1, and enter WAIT; div_q=0 produces a step after 1 RUN cycle.
REQ-024 WAIT: result and result_valid SHALL hold stable until result_ready=1; pause SHALL have no effect in WAIT.
REQ-025 WAIT with result_ready=1: the block SHALL set result_valid=0. If idx<len_q-1: idx+1 and go to RUN. If idx==len_q-1 and loop_q=1: idx=0 and go to RUN. If idx==len_q-1 and loop_q=0: done=1 for one cycle and go to IDLE.
REQ-026 With result_ready tied high and pause=0, one element SHALL be emitted every div_q+2 cycles; the first result_valid rises div_q+2 cycles after the edge that samples start.
REQ-027 result SHALL retain its last value after result_valid falls, until the next step.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge, with result_valid=0, no done pulse and idx=0.
REQ-029 Priority SHALL be reset > stop > start; start while busy SHALL be ignored.
REQ-030 A write in the same cycle as start SHALL complete, and playback SHALL read the updated memory.

Reset
REQ-031 On reset the block SHALL enter IDLE, clear result, result_valid, done, busy, idx and cnt, and clear div_q, len_q and loop_q.
REQ-032 On reset the pattern memory SHALL load the default pattern 0,0,8,5,7,0,0,5 into entries 0..7.
REQ-033 Reset asserted mid-playback, including in WAIT with result_valid=1, SHALL take effect on the next edge regardless of result_ready.

Verification
REQ-034 Default sequence: reset, then start with cfg_len=8, cfg_div=1, loop_en=0, result_ready=1 -> results 0,0,8,5,7,0,0,5, one every 3 cycles, the first 3 cycles after start; done pulses once after the 8th; busy falls.
REQ-035 Backpressure: result_ready=0 for 5 cycles while result_valid=1 -> result stable, no idx advance; the sequence resumes correctly after result_ready rises.
REQ-036 Loop and stop: cfg_len=3, loop_en=1 -> results 0,0,8,0,0,8,...; stop asserted in RUN -> IDLE next cycle, no done pulse.
REQ-037 Config and clamp: write entry 2 = 4'hF in IDLE, write entry 3 while busy (ignored), cfg_len=12 -> 8 elements with entry 2 = F and entry 3 = 5; start with cfg_len=0 -> busy stays 0.
REQ-038 Pause and reset: pause high for 4 cycles with cfg_div=2 -> step delayed exactly 4 cycles; reset asserted in WAIT -> all outputs 0 next cycle and memory restored to the default pattern.

Source files
------------

// File: rtl/seq_player_ctrl.sv
// Pattern sequencer: steps through an 8-entry pattern memory at a programmable
// rate and offers each entry downstream on a valid/ready handshake.
module seq_player_ctrl #(
    parameter int DATA_W = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [3:0]        cfg_len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [8];
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [3:0]        len_q;
    logic              loop_q;
    logic              arm_q;
    logic [2:0]        idx;

    function automatic logic [DATA_W-1:0] dflt(input int i);
        case (i)
            2:       return DATA_W'(8);
            3, 7:    return DATA_W'(5);
            4:       return DATA_W'(7);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            div_q        <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            arm_q        <= 1'b0;
            for (int i = 0; i < 8; i++) mem[i] <= dflt(i);
        end else begin
            done <= 1'b0;
            if (cfg_we && state == IDLE) mem[cfg_addr] <= cfg_data;
            if (stop) begin
                state        <= IDLE;
                busy         <= 1'b0;
                result_valid <= 1'b0;
                idx          <= '0;
                cnt          <= '0;
                arm_q        <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && cfg_len != 4'd0) begin
                        div_q  <= cfg_div;
                        len_q  <= (cfg_len > 4'd8) ? 4'd8 : cfg_len;
                        loop_q <= loop_en;
                        idx    <= '0;
                        cnt    <= '0;
                        // first step gets one extra setup cycle after start
                        arm_q  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                    RUN: if (!pause) begin
                        if (arm_q) begin
                            arm_q <= 1'b0;
                        end else if (cnt == div_q) begin
                            cnt          <= '0;
                            result       <= mem[idx];
                            result_valid <= 1'b1;
                            state        <= WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT: if (result_ready) begin
                        result_valid <= 1'b0;
                        if ({1'b0, idx} != len_q - 4'd1) begin
                            idx   <= idx + 3'd1;
                            state <= RUN;
                        end else if (loop_q) begin
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
